except_ctrl: RTL

- Exception arbiter and pipeline-flush sequencer: the producing side of the CP0 exception interface.
- Sits at the MEM stage. Collects per-instruction exception flags, decides whether an interrupt is pending (using CP0 status/cause, with forwarding of a WB-stage mtc0), and picks one exception by fixed priority.
- Drives the CP0 exception inputs (except_type, current instruction address, delay-slot flag).
- Issues a registered flush pulse plus a redirect PC to the pipeline controller. Also synchronizes the raw external interrupt lines before they reach CP0.

---
 rtl/except_ctrl_pkg.sv | 41 ++++
 rtl/except_ctrl_irq_sync.sv | 29 ++
 rtl/except_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/except_ctrl_pkg.sv
// Shared definitions for the exception controller: exception codes,
// CP0 register addresses, STATUS/CAUSE field positions and FSM states.
package except_ctrl_pkg;

  // Exception codes presented to CP0
  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_INV     = 32'h0000_000a;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  // CP0 register addresses
  localparam logic [4:0] CP0_ADDR_STATUS = 5'd12;
  localparam logic [4:0] CP0_ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_ADDR_EPC    = 5'd14;

  // STATUS / CAUSE field positions
  localparam int STATUS_IE_BIT  = 0;
  localparam int STATUS_EXL_BIT = 1;
  localparam int IM_LSB         = 8;
  localparam int IM_MSB         = 15;

  // CAUSE bits software may write: IP[1:0] (9:8), IV (23), WP (22)
  localparam logic [31:0] CAUSE_WR_MASK = 32'h00c0_0300;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // An interrupt is pending when an unmasked line is asserted, interrupts
  // are enabled and we are not already at exception level.
  function automatic logic int_pending(input logic [31:0] status,
                                       input logic [31:0] cause);
    return (|(cause[IM_MSB:IM_LSB] & status[IM_MSB:IM_LSB])) &&
           status[STATUS_IE_BIT] && !status[STATUS_EXL_BIT];
  endfunction

endpackage

// File: rtl/except_ctrl_irq_sync.sv
// Multi-flop synchronizer for the six raw external interrupt lines.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_irq,
  output logic [5:0] o_irq
);

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_line
      logic [SYNC_STAGES-1:0] sh_reg;

      // Shift the raw line through SYNC_STAGES flops
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          sh_reg <= '0;
        end else begin
          sh_reg <= {sh_reg[SYNC_STAGES-2:0], i_irq[gi]};
        end
      end

      assign o_irq[gi] = sh_reg[SYNC_STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/except_ctrl.sv
// MEM-stage exception arbiter and flush sequencer. Picks one exception by
// fixed priority, drives the CP0 exception inputs and issues a registered
// flush pulse with the redirect PC.
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_vld,
  input  logic [31:0] i_inst_addr,
  input  logic        i_delayslot_vld,
  input  logic        i_exc_syscall,
  input  logic        i_exc_invalid_inst,
  input  logic        i_exc_trap,
  input  logic        i_exc_overflow,
  input  logic        i_exc_eret,
  input  logic [31:0] i_cp0_status,
  input  logic [31:0] i_cp0_cause,
  input  logic [31:0] i_cp0_epc,
  input  logic        i_wb_cp0_w_en,
  input  logic [4:0]  i_wb_cp0_w_addr,
  input  logic [31:0] i_wb_cp0_w_data,
  input  logic [5:0]  i_interrupt,
  output logic [5:0]  o_interrupt,
  output logic [31:0] o_except_type,
  output logic [31:0] o_curr_inst_addr,
  output logic        o_delayslot_vld,
  output logic        o_flush,
  output logic [31:0] o_new_pc
);

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic        flush_reg;
  logic [31:0] new_pc_reg;

  logic [31:0] eff_status;
  logic [31:0] eff_cause;
  logic [31:0] eff_epc;
  logic        int_pend;
  logic [31:0] except_type;

  irq_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_irq_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_irq (i_interrupt),
    .o_irq (o_interrupt)
  );

  // Forward a same-cycle WB-stage mtc0 over the CP0 register values
  always_comb begin
    eff_status = i_cp0_status;
    eff_cause  = i_cp0_cause;
    eff_epc    = i_cp0_epc;
    if (i_wb_cp0_w_en) begin
      case (i_wb_cp0_w_addr)
        CP0_ADDR_STATUS: eff_status = i_wb_cp0_w_data;
        CP0_ADDR_CAUSE:  eff_cause  = (i_cp0_cause & ~CAUSE_WR_MASK) |
                                      (i_wb_cp0_w_data & CAUSE_WR_MASK);
        CP0_ADDR_EPC:    eff_epc    = i_wb_cp0_w_data;
        default:         ;
      endcase
    end
  end

  assign int_pend = int_pending(eff_status, eff_cause);

  // Fixed-priority exception selection; suppressed while flushing
  always_comb begin
    except_type = EXC_NONE;
    if (i_vld && (state_reg == ST_IDLE)) begin
      if (int_pend)                except_type = EXC_INT;
      else if (i_exc_syscall)      except_type = EXC_SYSCALL;
      else if (i_exc_invalid_inst) except_type = EXC_INV;
      else if (i_exc_trap)         except_type = EXC_TRAP;
      else if (i_exc_overflow)     except_type = EXC_OV;
      else if (i_exc_eret)         except_type = EXC_ERET;
    end
  end

  // Flush sequencer: one accepted exception holds flush for FLUSH_CYCLES
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      flush_reg  <= 1'b0;
      new_pc_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (except_type != EXC_NONE) begin
            state_reg  <= ST_FLUSH;
            flush_reg  <= 1'b1;
            new_pc_reg <= (except_type == EXC_ERET) ? eff_epc : EXC_VECTOR;
            cnt_reg    <= 4'(FLUSH_CYCLES - 1);
          end
        end
        ST_FLUSH: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            flush_reg <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Only a few CP0 fields drive interrupt detection; the rest are ignored
  logic unused_bits;
  assign unused_bits = ^{eff_status[31:16], eff_status[7:2],
                         eff_cause[31:16], eff_cause[7:0]};

  assign o_except_type    = except_type;
  assign o_curr_inst_addr = i_inst_addr;
  assign o_delayslot_vld  = i_delayslot_vld;
  assign o_flush          = flush_reg;
  assign o_new_pc         = new_pc_reg;

endmodule
